// File: rtl/alu_iter_pkg.sv
// Shared types for the iterative ALU: opcode and FSM state enumerations.
package alu_iter_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SRL = 3'd4,
        OP_SRA = 3'd5,
        OP_SLL = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/addsub_p.sv
// Add/subtract primitive in the {a,ci} +/- {b,1} form.
//   i_a, i_b : operands
//   i_ci     : carry in, placed below the operand LSB
//   i_sub    : 1 = subtract, 0 = add
//   o_res    : result bits [DATA_W:1] of the extended sum
//   o_co     : carry/borrow out (extended MSB)
//   o_x      : extended LSB (carry-chain tap)
// With i_ci=0 and i_sub=0 this is a plain a+b with carry out.
module addsub_p #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_ci,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_res,
    output logic              o_co,
    output logic              o_x
);

    logic [DATA_W+1:0] ext_a;
    logic [DATA_W+1:0] ext_b;
    logic [DATA_W+1:0] ext_r;

    always_comb begin
        ext_a = {1'b0, i_a, i_ci};
        ext_b = {1'b0, i_b, 1'b1};
        ext_r = i_sub ? (ext_a - ext_b) : (ext_a + ext_b);
    end

    assign o_co  = ext_r[DATA_W+1];
    assign o_res = ext_r[DATA_W:1];
    assign o_x   = ext_r[0];

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid / o_ready : request handshake (accepted only in IDLE)
//   i_op, i_a, i_b    : opcode and operands (i_b is the shift source)
//   i_ci, i_shamt     : carry in (ADD/SUB), shift amount
//   o_valid / i_ready : result handshake (results held in DONE)
//   o_res, o_hi       : result, MUL high half (0 otherwise)
//   o_co, o_x         : carry/borrow/last-shifted-out/|hi, extended add LSB
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter  int DATA_W  = 16,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_op,
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  logic               i_ci,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_res,
    output logic [DATA_W-1:0]  o_hi,
    output logic               o_co,
    output logic               o_x
);

    alu_state_e          state_q, state_d;
    alu_op_e             op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [2*DATA_W:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic                co_q, co_d;
    logic                x_q, x_d;

    logic [DATA_W-1:0]   as_a, as_b, as_res;
    logic                as_ci, as_sub, as_co, as_x;
    logic [DATA_W-1:0]   sh_next;
    logic                sh_out;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W:0]   mul_next;

    // The single adder serves ADD/SUB at accept time and the MUL accumulate
    // while in ST_MUL; the two uses never overlap.
    always_comb begin
        as_a   = i_a;
        as_b   = i_b;
        as_ci  = i_ci;
        as_sub = (alu_op_e'(i_op) == OP_SUB);
        if (state_q == ST_MUL) begin
            as_a   = acc_q[2*DATA_W-1:DATA_W];
            as_b   = a_q;
            as_ci  = 1'b0;
            as_sub = 1'b0;
        end
    end

    addsub_p #(.DATA_W(DATA_W)) u_addsub (
        .i_a   (as_a),
        .i_b   (as_b),
        .i_ci  (as_ci),
        .i_sub (as_sub),
        .o_res (as_res),
        .o_co  (as_co),
        .o_x   (as_x)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        co_d    = co_q;
        x_d     = x_q;

        case (op_q)
            OP_SLL: begin
                sh_next = {sh_q[DATA_W-2:0], 1'b0};
                sh_out  = sh_q[DATA_W-1];
            end
            OP_SRA: begin
                sh_next = {sh_q[DATA_W-1], sh_q[DATA_W-1:1]};
                sh_out  = sh_q[0];
            end
            default: begin
                sh_next = {1'b0, sh_q[DATA_W-1:1]};
                sh_out  = sh_q[0];
            end
        endcase

        // Shift-add step: acc = {carry, hi, lo}; add a into hi when lo[0]
        // is set, then shift the whole accumulator right by one.
        mul_sum  = acc_q[0] ? {as_co, as_res} : acc_q[2*DATA_W:DATA_W];
        mul_next = {mul_sum, acc_q[DATA_W-1:0]} >> 1;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    op_d = alu_op_e'(i_op);
                    hi_d = '0;
                    co_d = 1'b0;
                    x_d  = 1'b0;
                    case (alu_op_e'(i_op))
                        OP_ADD, OP_SUB: begin
                            res_d   = as_res;
                            co_d    = as_co;
                            x_d     = as_x;
                            state_d = ST_DONE;
                        end
                        OP_AND: begin
                            res_d   = i_a & i_b;
                            state_d = ST_DONE;
                        end
                        OP_XOR: begin
                            res_d   = i_a ^ i_b;
                            state_d = ST_DONE;
                        end
                        OP_SRL, OP_SRA, OP_SLL: begin
                            if (i_shamt == '0) begin
                                res_d   = i_b;
                                state_d = ST_DONE;
                            end else begin
                                sh_d    = i_b;
                                cnt_d   = i_shamt - SHAMT_W'(1);
                                state_d = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            a_d     = i_a;
                            acc_d   = {{(DATA_W+1){1'b0}}, i_b};
                            cnt_d   = SHAMT_W'(DATA_W-1);
                            state_d = ST_MUL;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    res_d   = sh_next;
                    co_d    = sh_out;
                    state_d = ST_DONE;
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    res_d   = mul_next[DATA_W-1:0];
                    hi_d    = mul_next[2*DATA_W-1:DATA_W];
                    co_d    = |mul_next[2*DATA_W-1:DATA_W];
                    x_d     = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            co_q    <= 1'b0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            co_q    <= co_d;
            x_q     <= x_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_res   = res_q;
    assign o_hi    = hi_q;
    assign o_co    = co_q;
    assign o_x     = x_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (DATA_W=16) against an arithmetic reference.
module tb_alu_iter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [2:0]    i_op;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          i_ci;
    logic [3:0]    i_shamt;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_res;
    logic [W-1:0]  o_hi;
    logic          o_co;
    logic          o_x;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        co;
        logic        x;
        int          lat;
    } exp_t;

    exp_t last_e;

    always #5 clk = ~clk;

    alu_iter #(.DATA_W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_ci    (i_ci),
        .i_shamt (i_shamt),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_hi    (o_hi),
        .o_co    (o_co),
        .o_x     (o_x)
    );

    function automatic exp_t model(input int op, input int unsigned a, input int unsigned b,
                                   input int unsigned ci, input int unsigned sh);
        exp_t   e;
        int     s;
        int     sb;
        longint p;
        e.res = '0;
        e.hi  = '0;
        e.co  = 1'b0;
        e.x   = 1'b0;
        e.lat = 1;
        case (op)
            0, 1: begin
                if (op == 0) s = int'(2*a + ci) + int'(2*b + 1);
                else         s = int'(2*a + ci) - int'(2*b + 1);
                if (s < 0) s = s + (1 << 18);
                e.res = 16'((s >> 1) & 'hFFFF);
                e.co  = 1'((s >> 17) & 1);
                e.x   = 1'(s & 1);
            end
            2: e.res = 16'(a & b);
            3: e.res = 16'(a ^ b);
            4, 5, 6: begin
                if (op == 4) e.res = 16'(b >> sh);
                if (op == 5) begin
                    sb    = (b >= 32768) ? int'(b) - 65536 : int'(b);
                    e.res = 16'(sb >>> sh);
                end
                if (op == 6) e.res = 16'(b << sh);
                if (sh != 0) begin
                    if (op == 6) e.co = 1'((b >> (16 - sh)) & 1);
                    else         e.co = 1'((b >> (sh - 1)) & 1);
                end
                e.lat = (sh == 0) ? 1 : int'(sh) + 1;
            end
            default: begin
                p     = longint'(a) * longint'(b);
                e.res = 16'(p);
                e.hi  = 16'(p >> 16);
                e.co  = ((p >> 16) != 0);
                e.lat = 17;
            end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at a falling edge in DONE.
    task automatic issue(input int op, input int unsigned a, input int unsigned b,
                         input int unsigned ci, input int unsigned sh, input string tag);
        exp_t e;
        int   lat;
        e = model(op, a, b, ci, sh);
        check({tag, "/ready"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_op    = 3'(op);
        i_a     = 16'(a);
        i_b     = 16'(b);
        i_ci    = 1'(ci);
        i_shamt = 4'(sh);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_op    = 3'($urandom);
        i_a     = 16'($urandom);
        i_b     = 16'($urandom);
        i_ci    = 1'($urandom);
        i_shamt = 4'($urandom);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, 32'(lat), 32'(e.lat));
        check({tag, "/res"}, 32'(o_res), 32'(e.res));
        check({tag, "/hi"}, 32'(o_hi), 32'(e.hi));
        check({tag, "/co"}, 32'(o_co), 32'(e.co));
        check({tag, "/x"}, 32'(o_x), 32'(e.x));
        check({tag, "/busy"}, 32'(o_ready), 32'd0);
        last_e = e;
    endtask

    task automatic finish_op(input string tag);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check({tag, "/drop"}, 32'(o_valid), 32'd0);
        check({tag, "/idle"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        i_ci    = 1'b0;
        i_shamt = '0;
        repeat (2) @(negedge clk);
        check("rst/ready", 32'(o_ready), 32'd1);
        check("rst/valid", 32'(o_valid), 32'd0);
        check("rst/res", 32'(o_res), 32'd0);
        check("rst/hi", 32'(o_hi), 32'd0);
        check("rst/co", 32'(o_co), 32'd0);
        check("rst/x", 32'(o_x), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 'hFFFF, 'h0001, 1, 0, "add");
        check("add/lit", {15'd0, o_co, o_res}, {15'd0, 1'b1, 16'h0001});
        finish_op("add");

        issue(1, 'h0005, 'h0007, 1, 0, "sub");
        check("sub/lit", {15'd0, o_co, o_res}, {15'd0, 1'b1, 16'hFFFE});
        finish_op("sub");
        issue(1, 'h0000, 'hFFFF, 0, 0, "sub_ones");
        finish_op("sub_ones");

        issue(5, 0, 'h8004, 0, 3, "sra");
        check("sra/lit", {15'd0, o_co, o_res}, {15'd0, 1'b1, 16'hF000});
        finish_op("sra");
        issue(4, 0, 'h8004, 0, 3, "srl");
        check("srl/lit", 32'(o_res), 32'h1000);
        finish_op("srl");
        issue(5, 0, 'h8004, 0, 0, "sra0");
        check("sra0/lit", {15'd0, o_co, o_res}, {15'd0, 1'b0, 16'h8004});
        finish_op("sra0");
        issue(6, 0, 'h8001, 0, 15, "sll15");
        finish_op("sll15");

        issue(7, 'hFFFF, 'hFFFF, 0, 0, "mul_max");
        check("mul_max/lit", {o_hi, o_res}, 32'hFFFE0001);
        finish_op("mul_max");

        // Backpressure: hold the MUL result while inputs churn.
        issue(7, 'h1234, 'h0100, 0, 0, "mul");
        check("mul/lit", {o_hi, o_res}, 32'h00123400);
        for (int i = 0; i < 5; i++) begin
            i_valid = ~i_valid;
            i_op    = 3'($urandom);
            i_a     = 16'($urandom);
            i_b     = 16'($urandom);
            i_shamt = 4'($urandom);
            @(negedge clk);
            check("bp/valid", 32'(o_valid), 32'd1);
            check("bp/ready", 32'(o_ready), 32'd0);
            check("bp/res", {o_hi, o_res}, {last_e.hi, last_e.res});
            check("bp/co", 32'(o_co), 32'(last_e.co));
        end
        i_valid = 1'b0;
        finish_op("bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp/noextra", 32'(o_valid), 32'd0);
        end

        // Reset in the middle of a multiply.
        i_valid = 1'b1;
        i_op    = 3'd7;
        i_a     = 16'h00FF;
        i_b     = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mrst/ready", 32'(o_ready), 32'd1);
        check("mrst/valid", 32'(o_valid), 32'd0);
        check("mrst/out", {o_hi, o_res}, 32'd0);
        check("mrst/flags", {30'd0, o_co, o_x}, 32'd0);
        issue(0, 'h1111, 'h2222, 0, 0, "post_rst");
        finish_op("post_rst");

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 7)), $urandom_range(0, 'hFFFF), $urandom_range(0, 'hFFFF),
                  $urandom_range(0, 1), $urandom_range(0, 15), "rnd");
            finish_op("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
